pipelined_control_unit: RTL and testbench

- Next-generation control for the 5-stage ARM pipeline. Decodes Op/Funct/Rd in Decode.
- Registers the controls through Execute, Memory and Writeback, with flush on Execute.
- Holds the NZCV flag register and evaluates the condition field in Execute, so conditional execution, CMP/TST and predicated PC writes live in one block.

---
 rtl/arm_ctrl_pkg.sv | 54 +++++
 rtl/cond_check.sv | 38 +++
 rtl/pipelined_control_unit.sv | 198 +++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the pipelined ARM control unit: ALU operations, instruction
// classes, data-processing commands, condition codes and the Decode->Execute bundle.
package arm_ctrl_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Funct[4:1] command field of data-processing instructions
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic [3:0] cond;
        logic [2:0] aluCtrl;
        logic       aluSrc;
        logic       memtoReg;
        logic       regWrite;
        logic       memWrite;
        logic       branch;
        logic       noWrite;
        logic [1:0] flagWrite;
        logic       pcSrc;
    } ctrlDE_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluation against the current NZCV flags.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic flagN, flagZ, flagC, flagV;

    assign {flagN, flagZ, flagC, flagV} = Flags;

    // Condition decode; the 1111 encoding never passes
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = flagZ;
            COND_NE: CondEx = ~flagZ;
            COND_CS: CondEx = flagC;
            COND_CC: CondEx = ~flagC;
            COND_MI: CondEx = flagN;
            COND_PL: CondEx = ~flagN;
            COND_VS: CondEx = flagV;
            COND_VC: CondEx = ~flagV;
            COND_HI: CondEx = flagC & ~flagZ;
            COND_LS: CondEx = ~flagC | flagZ;
            COND_GE: CondEx = (flagN == flagV);
            COND_LT: CondEx = (flagN != flagV);
            COND_GT: CondEx = ~flagZ & (flagN == flagV);
            COND_LE: CondEx = flagZ | (flagN != flagV);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Control unit for the 5-stage ARM pipeline: Decode-stage decode, E/M/W control
// registers, NZCV flag register and Execute-stage predication.
module pipelined_control_unit
    import arm_ctrl_pkg::*;
#(
    parameter int         ALUCTRL_W = 3,
    parameter logic [3:0] PC_REG    = 4'd15,
    parameter bit         EXT_OPS   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           CondD,
    input  logic [1:0]           OpD,
    input  logic [5:0]           FunctD,
    input  logic [3:0]           RdD,
    input  logic                 FlushE,
    input  logic [3:0]           ALUFlagsE,
    output logic [1:0]           RegSrcD,
    output logic [1:0]           ImmSrcD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 MemtoRegE,
    output logic                 BranchTakenE,
    output logic [3:0]           FlagsE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 MemtoRegW,
    output logic                 RegWriteW,
    output logic                 PCSrcW,
    output logic                 PCWrPendingF
);

    ctrlDE_t    decRaw;
    ctrlDE_t    decD;
    ctrlDE_t    ctrlE;
    logic [1:0] regSrcRaw;
    logic [1:0] immSrcRaw;
    logic       aluOp;
    logic       isArith;
    logic       bubble;
    logic       killD;
    logic       condExE;
    logic [3:0] flagReg;
    logic       memtoRegM;
    logic       pcSrcM;

    // Main and ALU decode; unsupported encodings collapse to a bubble
    always_comb begin
        decRaw      = '0;
        regSrcRaw   = 2'b00;
        immSrcRaw   = 2'b00;
        aluOp       = 1'b0;
        isArith     = 1'b0;
        bubble      = 1'b0;
        decRaw.cond = CondD;
        case (OpD)
            OP_DP: begin
                decRaw.aluSrc   = FunctD[5];
                decRaw.regWrite = 1'b1;
                aluOp           = 1'b1;
            end
            OP_MEM: begin
                immSrcRaw     = 2'b01;
                decRaw.aluSrc = 1'b1;
                if (FunctD[0]) begin
                    decRaw.memtoReg = 1'b1;
                    decRaw.regWrite = 1'b1;
                end else begin
                    regSrcRaw       = 2'b10;
                    decRaw.memWrite = 1'b1;
                end
            end
            OP_BR: begin
                regSrcRaw     = 2'b01;
                immSrcRaw     = 2'b10;
                decRaw.aluSrc = 1'b1;
                decRaw.branch = 1'b1;
            end
            default: bubble = 1'b1;
        endcase
        if (aluOp) begin
            case (FunctD[4:1])
                CMD_ADD: begin
                    decRaw.aluCtrl = ALU_ADD;
                    isArith        = 1'b1;
                end
                CMD_SUB: begin
                    decRaw.aluCtrl = ALU_SUB;
                    isArith        = 1'b1;
                end
                CMD_AND: decRaw.aluCtrl = ALU_AND;
                CMD_ORR: decRaw.aluCtrl = ALU_ORR;
                CMD_EOR: begin
                    if (EXT_OPS) begin
                        decRaw.aluCtrl = ALU_EOR;
                    end else begin
                        bubble = 1'b1;
                    end
                end
                CMD_CMP: begin
                    if (EXT_OPS) begin
                        decRaw.aluCtrl = ALU_SUB;
                        decRaw.noWrite = 1'b1;
                        isArith        = 1'b1;
                    end else begin
                        bubble = 1'b1;
                    end
                end
                CMD_TST: begin
                    if (EXT_OPS) begin
                        decRaw.aluCtrl = ALU_AND;
                        decRaw.noWrite = 1'b1;
                    end else begin
                        bubble = 1'b1;
                    end
                end
                default: bubble = 1'b1;
            endcase
        end else begin
            decRaw.aluCtrl = ALU_ADD;
        end
        decRaw.flagWrite = {FunctD[0] & aluOp, FunctD[0] & aluOp & isArith};
        decRaw.pcSrc     = ((RdD == PC_REG) & decRaw.regWrite & ~decRaw.noWrite) | decRaw.branch;
    end

    // Reset also silences Decode so nothing is reported while the pipe is held
    assign killD   = bubble | reset;
    assign decD    = killD ? '0 : decRaw;
    assign RegSrcD = killD ? 2'b00 : regSrcRaw;
    assign ImmSrcD = killD ? 2'b00 : immSrcRaw;

    cond_check uCondCheck (
        .Cond   (ctrlE.cond),
        .Flags  (flagReg),
        .CondEx (condExE)
    );

    // Decode->Execute register; flush inserts a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrlE <= '0;
        end else if (FlushE) begin
            ctrlE <= '0;
        end else begin
            ctrlE <= decD;
        end
    end

    // Execute->Memory register, side effects qualified by the condition result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            memtoRegM <= 1'b0;
            pcSrcM    <= 1'b0;
        end else begin
            RegWriteM <= ctrlE.regWrite & condExE & ~ctrlE.noWrite;
            MemWriteM <= ctrlE.memWrite & condExE;
            memtoRegM <= ctrlE.memtoReg;
            pcSrcM    <= ctrlE.pcSrc & condExE;
        end
    end

    // Memory->Writeback register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            PCSrcW    <= 1'b0;
        end else begin
            RegWriteW <= RegWriteM;
            MemtoRegW <= memtoRegM;
            PCSrcW    <= pcSrcM;
        end
    end

    // NZCV register: N,Z and C,V have independent write enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flagReg <= 4'b0000;
        end else begin
            if (ctrlE.flagWrite[1] & condExE) begin
                flagReg[3:2] <= ALUFlagsE[3:2];
            end
            if (ctrlE.flagWrite[0] & condExE) begin
                flagReg[1:0] <= ALUFlagsE[1:0];
            end
        end
    end

    assign ALUControlE  = ALUCTRL_W'(ctrlE.aluCtrl);
    assign ALUSrcE      = ctrlE.aluSrc;
    assign MemtoRegE    = ctrlE.memtoReg;
    assign BranchTakenE = ctrlE.branch & condExE;
    assign FlagsE       = flagReg;
    assign PCWrPendingF = decD.pcSrc | ctrlE.pcSrc | pcSrcM;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: decode table, directed pipeline
// sequences and randomized instruction streams against an instruction-level model.
module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] CondD;
    logic [1:0] OpD;
    logic [5:0] FunctD;
    logic [3:0] RdD;
    logic       FlushE;
    logic [3:0] ALUFlagsE;

    logic [1:0] RegSrcD, ImmSrcD;
    logic [2:0] ALUControlE;
    logic       ALUSrcE, MemtoRegE, BranchTakenE;
    logic [3:0] FlagsE;
    logic       RegWriteM, MemWriteM, MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF;

    logic [1:0] xRegSrcD, xImmSrcD;
    logic [2:0] xALUControlE;
    logic       xALUSrcE, xMemtoRegE, xBranchTakenE;
    logic [3:0] xFlagsE;
    logic       xRegWriteM, xMemWriteM, xMemtoRegW, xRegWriteW, xPCSrcW, xPCWrPendingF;

    pipelined_control_unit dut (
        .clk(clk), .reset(reset), .CondD(CondD), .OpD(OpD), .FunctD(FunctD), .RdD(RdD),
        .FlushE(FlushE), .ALUFlagsE(ALUFlagsE), .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE),
        .BranchTakenE(BranchTakenE), .FlagsE(FlagsE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW),
        .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF)
    );

    pipelined_control_unit #(.EXT_OPS(1'b0)) dutNoExt (
        .clk(clk), .reset(reset), .CondD(CondD), .OpD(OpD), .FunctD(FunctD), .RdD(RdD),
        .FlushE(FlushE), .ALUFlagsE(ALUFlagsE), .RegSrcD(xRegSrcD), .ImmSrcD(xImmSrcD),
        .ALUControlE(xALUControlE), .ALUSrcE(xALUSrcE), .MemtoRegE(xMemtoRegE),
        .BranchTakenE(xBranchTakenE), .FlagsE(xFlagsE), .RegWriteM(xRegWriteM),
        .MemWriteM(xMemWriteM), .MemtoRegW(xMemtoRegW), .RegWriteW(xRegWriteW),
        .PCSrcW(xPCSrcW), .PCWrPendingF(xPCWrPendingF)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] regSrc;
        logic [1:0] immSrc;
        logic [2:0] alu;
        logic       aluSrc, memtoReg, regWrite, memWrite, branch, noWrite, fwNZ, fwCV, pcSrc;
        logic [3:0] cond;
    } ctl_t;

    typedef struct packed {
        logic regWrite, memWrite, memtoReg, pcSrc;
    } eff_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [1:0] rs;
        logic [1:0] is;
        logic [2:0] alu;
        logic       src, mtr, rw, mw;
        logic [2:0] xalu;
        logic       xrw;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    ctl_t eInst;
    eff_t mEff, wEff;
    logic [3:0] mFlags;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction-level decode from the mnemonic table
    function automatic ctl_t modelDecode(input logic [3:0] cond, input logic [1:0] op,
                                         input logic [5:0] funct, input logic [3:0] rd,
                                         input bit ext);
        ctl_t c;
        logic [3:0] cmd;
        logic [2:0] alu;
        bit known, arith, nw;
        c = '0; cmd = funct[4:1]; alu = 3'd0; known = 1'b1; arith = 1'b0; nw = 1'b0;
        if (op == 2'b11) return c;
        if (op == 2'b10) begin
            c.regSrc = 2'b01; c.immSrc = 2'b10; c.aluSrc = 1'b1; c.branch = 1'b1;
        end else if (op == 2'b01) begin
            c.immSrc = 2'b01; c.aluSrc = 1'b1;
            c.regSrc = funct[0] ? 2'b00 : 2'b10;
            c.memWrite = ~funct[0]; c.memtoReg = funct[0]; c.regWrite = funct[0];
        end else begin
            if (cmd == 4'b0100) begin alu = 3'd0; arith = 1'b1; end
            else if (cmd == 4'b0010) begin alu = 3'd1; arith = 1'b1; end
            else if (cmd == 4'b0000) alu = 3'd2;
            else if (cmd == 4'b1100) alu = 3'd3;
            else if (ext && cmd == 4'b0001) alu = 3'd4;
            else if (ext && cmd == 4'b1010) begin alu = 3'd1; arith = 1'b1; nw = 1'b1; end
            else if (ext && cmd == 4'b1000) begin alu = 3'd2; nw = 1'b1; end
            else known = 1'b0;
            if (!known) return c;
            c.alu = alu; c.aluSrc = funct[5]; c.regWrite = 1'b1; c.noWrite = nw;
            c.fwNZ = funct[0]; c.fwCV = funct[0] & arith;
        end
        c.cond  = cond;
        c.pcSrc = (rd == 4'd15 && c.regWrite && !c.noWrite) || c.branch;
        return c;
    endfunction

    // Condition as base predicate on Cond[3:1], inverted by Cond[0]
    function automatic logic condPass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        base = 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: return (c[0] == 1'b0);
        endcase
        return base ^ c[0];
    endfunction

    // One clock: drive inputs, compare every output with the model, advance the model
    task automatic cycle(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd, input logic flush, input logic [3:0] af,
                         input logic rst);
        ctl_t d;
        logic pass;
        eff_t nm;
        @(posedge clk);
        #1;
        reset = rst; CondD = cond; OpD = op; FunctD = funct; RdD = rd;
        FlushE = flush; ALUFlagsE = af;
        @(negedge clk);
        if (rst) begin
            d = '0; eInst = '0; mEff = '0; wEff = '0; mFlags = 4'b0000;
        end else begin
            d = modelDecode(cond, op, funct, rd, 1'b1);
        end
        pass = condPass(eInst.cond, mFlags);
        chk("RegSrcD", 8'(RegSrcD), 8'(d.regSrc));
        chk("ImmSrcD", 8'(ImmSrcD), 8'(d.immSrc));
        chk("ALUControlE", 8'(ALUControlE), 8'(eInst.alu));
        chk("ALUSrcE", 8'(ALUSrcE), 8'(eInst.aluSrc));
        chk("MemtoRegE", 8'(MemtoRegE), 8'(eInst.memtoReg));
        chk("BranchTakenE", 8'(BranchTakenE), 8'(eInst.branch & pass));
        chk("FlagsE", 8'(FlagsE), 8'(mFlags));
        chk("RegWriteM", 8'(RegWriteM), 8'(mEff.regWrite));
        chk("MemWriteM", 8'(MemWriteM), 8'(mEff.memWrite));
        chk("MemtoRegW", 8'(MemtoRegW), 8'(wEff.memtoReg));
        chk("RegWriteW", 8'(RegWriteW), 8'(wEff.regWrite));
        chk("PCSrcW", 8'(PCSrcW), 8'(wEff.pcSrc));
        chk("PCWrPendingF", 8'(PCWrPendingF), 8'(d.pcSrc | eInst.pcSrc | mEff.pcSrc));
        if (!rst) begin
            nm.regWrite = eInst.regWrite & pass & ~eInst.noWrite;
            nm.memWrite = eInst.memWrite & pass;
            nm.memtoReg = eInst.memtoReg;
            nm.pcSrc    = eInst.pcSrc & pass;
            wEff = mEff;
            mEff = nm;
            if (eInst.fwNZ & pass) mFlags[3:2] = af[3:2];
            if (eInst.fwCV & pass) mFlags[1:0] = af[1:0];
            eInst = flush ? '0 : d;
        end
    endtask

    task automatic nop(input logic [3:0] af);
        cycle(4'b1110, 2'b11, 6'd0, 4'd0, 1'b0, af, 1'b0);
    endtask

    vec_t tbl [13];
    logic [3:0] rc, rr, raf;
    logic [1:0] ro;
    logic [5:0] rf;
    logic rfl, rrst;

    initial begin
        tbl[0]  = '{2'b00, 6'b001000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1};
        tbl[1]  = '{2'b00, 6'b100100, 2'b00, 2'b00, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1};
        tbl[2]  = '{2'b00, 6'b000000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1};
        tbl[3]  = '{2'b00, 6'b111000, 2'b00, 2'b00, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 3'b011, 1'b1};
        tbl[4]  = '{2'b00, 6'b000011, 2'b00, 2'b00, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
        tbl[5]  = '{2'b00, 6'b110101, 2'b00, 2'b00, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
        tbl[6]  = '{2'b00, 6'b110001, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
        tbl[7]  = '{2'b00, 6'b001100, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
        tbl[8]  = '{2'b01, 6'b011000, 2'b10, 2'b01, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0};
        tbl[9]  = '{2'b01, 6'b011001, 2'b00, 2'b01, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1};
        tbl[10] = '{2'b10, 6'b100000, 2'b01, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
        tbl[11] = '{2'b11, 6'b111111, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
        tbl[12] = '{2'b11, 6'b001001, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};

        reset = 1'b1; CondD = 4'b1110; OpD = 2'b11; FunctD = 6'd0; RdD = 4'd0;
        FlushE = 1'b0; ALUFlagsE = 4'b0000;
        eInst = '0; mEff = '0; wEff = '0; mFlags = 4'b0000;

        cycle(4'b1110, 2'b00, 6'b101001, 4'd15, 1'b0, 4'b1111, 1'b1);
        chk("reset RegSrcD", 8'(RegSrcD), 8'h00);
        chk("reset PCWrPendingF", 8'(PCWrPendingF), 8'h00);
        cycle(4'b1110, 2'b11, 6'd0, 4'd0, 1'b0, 4'b0000, 1'b1);
        chk("reset FlagsE", 8'(FlagsE), 8'h00);
        chk("reset RegWriteW", 8'(RegWriteW), 8'h00);

        // Decode table on both configurations
        for (int i = 0; i < 13; i++) begin
            cycle(4'b1110, tbl[i].op, tbl[i].funct, 4'd0, 1'b0, 4'b0000, 1'b0);
            chk($sformatf("tbl%0d RegSrcD", i), 8'(RegSrcD), 8'(tbl[i].rs));
            chk($sformatf("tbl%0d ImmSrcD", i), 8'(ImmSrcD), 8'(tbl[i].is));
            nop(4'b0000);
            chk($sformatf("tbl%0d ALUControlE", i), 8'(ALUControlE), 8'(tbl[i].alu));
            chk($sformatf("tbl%0d ALUSrcE", i), 8'(ALUSrcE), 8'(tbl[i].src));
            chk($sformatf("tbl%0d MemtoRegE", i), 8'(MemtoRegE), 8'(tbl[i].mtr));
            chk($sformatf("tbl%0d noext ALUControlE", i), 8'(xALUControlE), 8'(tbl[i].xalu));
            nop(4'b0000);
            chk($sformatf("tbl%0d RegWriteM", i), 8'(RegWriteM), 8'(tbl[i].rw));
            chk($sformatf("tbl%0d MemWriteM", i), 8'(MemWriteM), 8'(tbl[i].mw));
            chk($sformatf("tbl%0d noext RegWriteM", i), 8'(xRegWriteM), 8'(tbl[i].xrw));
        end

        // Flag chain: ADDS sets Z, following BEQ taken; then Z clear, BEQ not taken
        cycle(4'b1110, 2'b00, 6'b101001, 4'd1, 1'b0, 4'b0000, 1'b0);
        cycle(4'b0000, 2'b10, 6'd0, 4'd0, 1'b0, 4'b0100, 1'b0);
        chk("ADDS ALUControlE", 8'(ALUControlE), 8'h00);
        nop(4'b0000);
        chk("ADDS FlagsE", 8'(FlagsE), 8'h04);
        chk("BEQ taken", 8'(BranchTakenE), 8'h01);
        cycle(4'b1110, 2'b00, 6'b101001, 4'd1, 1'b0, 4'b0000, 1'b0);
        cycle(4'b0000, 2'b10, 6'd0, 4'd0, 1'b0, 4'b0000, 1'b0);
        nop(4'b0000);
        chk("ADDS clr FlagsE", 8'(FlagsE), 8'h00);
        chk("BEQ not taken", 8'(BranchTakenE), 8'h00);

        // CMP updates all flags without a register write; TST only N,Z
        cycle(4'b1110, 2'b00, 6'b110101, 4'd0, 1'b0, 4'b0000, 1'b0);
        nop(4'b1011);
        chk("CMP ALUControlE", 8'(ALUControlE), 8'h01);
        nop(4'b0000);
        chk("CMP RegWriteM", 8'(RegWriteM), 8'h00);
        chk("CMP FlagsE", 8'(FlagsE), 8'h0b);
        cycle(4'b1110, 2'b00, 6'b110001, 4'd0, 1'b0, 4'b0000, 1'b0);
        nop(4'b0110);
        nop(4'b0000);
        chk("TST FlagsE", 8'(FlagsE), 8'h07);
        chk("TST RegWriteM", 8'(RegWriteM), 8'h00);

        // ADDNE to PC with Z=1: squashed
        cycle(4'b0001, 2'b00, 6'b001000, 4'd15, 1'b0, 4'b0000, 1'b0);
        chk("ADDNE z1 pending D", 8'(PCWrPendingF), 8'h01);
        nop(4'b0000);
        chk("ADDNE z1 pending E", 8'(PCWrPendingF), 8'h01);
        nop(4'b0000);
        chk("ADDNE z1 RegWriteM", 8'(RegWriteM), 8'h00);
        nop(4'b0000);
        chk("ADDNE z1 RegWriteW", 8'(RegWriteW), 8'h00);
        chk("ADDNE z1 PCSrcW", 8'(PCSrcW), 8'h00);
        // Clear Z, then ADDNE to PC executes
        cycle(4'b1110, 2'b00, 6'b101001, 4'd1, 1'b0, 4'b0000, 1'b0);
        nop(4'b0000);
        cycle(4'b0001, 2'b00, 6'b001000, 4'd15, 1'b0, 4'b0000, 1'b0);
        chk("ADDNE z0 pending D", 8'(PCWrPendingF), 8'h01);
        nop(4'b0000);
        chk("ADDNE z0 pending E", 8'(PCWrPendingF), 8'h01);
        nop(4'b0000);
        chk("ADDNE z0 pending M", 8'(PCWrPendingF), 8'h01);
        chk("ADDNE z0 PCSrcW early", 8'(PCSrcW), 8'h00);
        nop(4'b0000);
        chk("ADDNE z0 PCSrcW", 8'(PCSrcW), 8'h01);
        chk("ADDNE z0 RegWriteW", 8'(RegWriteW), 8'h01);
        chk("ADDNE z0 pending after", 8'(PCWrPendingF), 8'h00);

        // Flush a flag-setting ADDS; the next ADD proceeds
        cycle(4'b1110, 2'b00, 6'b101001, 4'd3, 1'b1, 4'b0000, 1'b0);
        cycle(4'b1110, 2'b00, 6'b001000, 4'd2, 1'b0, 4'b1111, 1'b0);
        nop(4'b0000);
        chk("flush FlagsE", 8'(FlagsE), 8'h00);
        chk("flush RegWriteM", 8'(RegWriteM), 8'h00);
        nop(4'b0000);
        chk("post-flush RegWriteM", 8'(RegWriteM), 8'h01);

        // Reset with a STR in Execute
        cycle(4'b1110, 2'b00, 6'b101001, 4'd1, 1'b0, 4'b0000, 1'b0);
        cycle(4'b1110, 2'b01, 6'b011000, 4'd0, 1'b0, 4'b1010, 1'b0);
        cycle(4'b1110, 2'b01, 6'b011000, 4'd0, 1'b0, 4'b0000, 1'b1);
        chk("rst STR MemWriteM", 8'(MemWriteM), 8'h00);
        chk("rst STR FlagsE", 8'(FlagsE), 8'h00);
        chk("rst STR ALUSrcE", 8'(ALUSrcE), 8'h00);
        chk("rst STR RegSrcD", 8'(RegSrcD), 8'h00);
        cycle(4'b1110, 2'b01, 6'b011000, 4'd0, 1'b0, 4'b0000, 1'b1);
        nop(4'b0000);
        chk("post-rst MemWriteM", 8'(MemWriteM), 8'h00);
        nop(4'b0000);
        chk("post-rst MemWriteM 2", 8'(MemWriteM), 8'h00);
        chk("post-rst FlagsE", 8'(FlagsE), 8'h00);

        // Randomized instruction stream
        for (int i = 0; i < 600; i++) begin
            ro = 2'($urandom_range(0, 3));
            rf = 6'($urandom);
            case ($urandom_range(0, 7))
                0: rf[4:1] = 4'b0100;
                1: rf[4:1] = 4'b0010;
                2: rf[4:1] = 4'b0000;
                3: rf[4:1] = 4'b1100;
                4: rf[4:1] = 4'b0001;
                5: rf[4:1] = 4'b1010;
                6: rf[4:1] = 4'b1000;
                default: ;
            endcase
            rc   = ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom);
            rr   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            rfl  = ($urandom_range(0, 9) == 0);
            rrst = ($urandom_range(0, 59) == 0);
            raf  = 4'($urandom);
            cycle(rc, ro, rf, rr, rfl, raf, rrst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
